// File: rtl/rotor_phase_startup_controller_pkg.sv
// Shared definitions for the rotor phase startup controller.
//   - state_e      : controller state encoding (also the state_out value)
//   - fault_code_e : latched fault reason
//   - hall_is_legal / hall_successor / hall_is_adjacent : hall code rules.
//     Forward electrical order is 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
package rotor_phase_startup_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_FORECAST = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_SKIP    = 2'b10,
    FC_STALL   = 2'b11
  } fault_code_e;

  localparam logic [2:0] HALL_ALL_LOW  = 3'b000;
  localparam logic [2:0] HALL_ALL_HIGH = 3'b111;

  function automatic logic hall_is_legal(input logic [2:0] code);
    return (code != HALL_ALL_LOW) && (code != HALL_ALL_HIGH);
  endfunction

  // Next code in the forward direction; illegal codes map to 000 so they
  // can never look adjacent to a legal code.
  function automatic logic [2:0] hall_successor(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b101:  nxt = 3'b100;
      3'b100:  nxt = 3'b110;
      3'b110:  nxt = 3'b010;
      3'b010:  nxt = 3'b011;
      3'b011:  nxt = 3'b001;
      3'b001:  nxt = 3'b101;
      default: nxt = HALL_ALL_LOW;
    endcase
    return nxt;
  endfunction

  // True when b is one step forward or backward from a.
  function automatic logic hall_is_adjacent(input logic [2:0] a, input logic [2:0] b);
    return (hall_successor(a) == b) || (hall_successor(b) == a);
  endfunction

endpackage

// File: rtl/rotor_phase_startup_controller_hall_input_filter.sv
// Hall input conditioning: 2-flop synchroniser followed by a debounce filter.
// Ports:
//   sys_clk, reset_n   : clock, asynchronous active-low reset
//   hall_raw_in[2:0]   : raw {u,v,w} hall sensors (asynchronous)
//   hall_filtered_out  : code accepted after DEBOUNCE_CYCLES equal samples
//   hall_prev_out      : filtered code held before the most recent change
//   hall_edge_out      : high in the first cycle hall_filtered_out shows a new code
// Input-to-output latency is 2 + DEBOUNCE_CYCLES cycles.
module rotor_phase_startup_controller_hall_input_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic [2:0] hall_raw_in,
  output logic [2:0] hall_filtered_out,
  output logic [2:0] hall_prev_out,
  output logic       hall_edge_out
);

  localparam int             CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_N = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  ONE   = CW'(1);

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q, cand_d;
  logic [2:0]    filt_q, filt_d;
  logic [2:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          edge_q, edge_d;

  // cand_q is the value currently being timed; cnt_q is how many consecutive
  // synced samples have matched it (saturating at DEBOUNCE_CYCLES).
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    prev_d = prev_q;
    edge_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = ONE;
    end else if (cnt_q < DEB_N) begin
      cnt_d = cnt_q + ONE;
    end
    if ((cnt_d == DEB_N) && (cand_d != filt_q)) begin
      filt_d = cand_d;
      prev_d = filt_q;
      edge_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= hall_raw_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign hall_filtered_out = filt_q;
  assign hall_prev_out     = prev_q;
  assign hall_edge_out     = edge_q;

endmodule

// File: rtl/rotor_phase_startup_controller.sv
// Rotor angle acquisition sequencer for the PMSM FOC loop.
// Filters the hall sensors, waits for a stable legal code, pulses the angle
// calculator's phase-forecast enable for two cycles, then releases it into
// tracking and supervises illegal codes, skipped steps and stall. Also
// measures the hall-edge period while tracking.
// Ports:
//   sys_clk, reset_n          : clock, asynchronous active-low reset
//   start_in / stop_in        : startup request / abort to IDLE
//   fault_clear_in            : leave FAULT and clear the latched code
//   stall_check_enable_in     : speed commanded, stall supervision active
//   hall_u_in/v_in/w_in       : raw hall sensors
//   hall_filtered_out         : debounced {u,v,w}
//   forecast_enable_out       : calculator phase-forecast enable
//   tracking_active_out       : angle valid (RUN)
//   hall_period_out / _valid  : cycles between last two hall edges + strobe
//   state_out                 : IDLE=0 SETTLE=1 FORECAST=2 RUN=3 FAULT=4
//   fault_out, fault_code_out : latched fault, 01 illegal / 10 skip / 11 stall
module rotor_phase_startup_controller
  import rotor_phase_startup_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 1000,
  parameter int STALL_TIMEOUT   = 2000000,
  parameter int CNT_WIDTH       = 24
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic                 fault_clear_in,
  input  logic                 stall_check_enable_in,
  input  logic                 hall_u_in,
  input  logic                 hall_v_in,
  input  logic                 hall_w_in,
  output logic [2:0]           hall_filtered_out,
  output logic                 forecast_enable_out,
  output logic                 tracking_active_out,
  output logic [CNT_WIDTH-1:0] hall_period_out,
  output logic                 hall_period_valid_out,
  output logic [2:0]           state_out,
  output logic                 fault_out,
  output logic [1:0]           fault_code_out
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STALL_LAST  = CNT_WIDTH'(STALL_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  fault_code_e            fault_code_q, fault_code_d;
  logic [CNT_WIDTH-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   seen_edge_q, seen_edge_d;
  logic                   fc_cnt_q, fc_cnt_d;

  logic [2:0]  hall_raw, hall_prev;
  logic        hall_edge;
  logic        code_legal, skip_step, stall_hit, fault_hit, run_edge;
  fault_code_e fault_kind;

  assign hall_raw = {hall_u_in, hall_v_in, hall_w_in};

  rotor_phase_startup_controller_hall_input_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hall_filter (
    .sys_clk          (sys_clk),
    .reset_n          (reset_n),
    .hall_raw_in      (hall_raw),
    .hall_filtered_out(hall_filtered_out),
    .hall_prev_out    (hall_prev),
    .hall_edge_out    (hall_edge)
  );

  // Supervision. Reporting priority in RUN: illegal, then skip, then stall.
  always_comb begin
    code_legal = hall_is_legal(hall_filtered_out);
    skip_step  = hall_edge && !hall_is_adjacent(hall_prev, hall_filtered_out);
    stall_hit  = stall_check_enable_in && !hall_edge && (stall_cnt_q >= STALL_LAST);
    fault_hit  = 1'b0;
    fault_kind = FC_NONE;
    case (state_q)
      ST_SETTLE, ST_FORECAST: begin
        if (!code_legal) begin
          fault_hit  = 1'b1;
          fault_kind = FC_ILLEGAL;
        end
      end
      ST_RUN: begin
        if (!code_legal) begin
          fault_hit  = 1'b1;
          fault_kind = FC_ILLEGAL;
        end else if (skip_step) begin
          fault_hit  = 1'b1;
          fault_kind = FC_SKIP;
        end else if (stall_hit) begin
          fault_hit  = 1'b1;
          fault_kind = FC_STALL;
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: a fault beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stop_in)       state_d = ST_IDLE;
        else if (start_in) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (fault_hit)     state_d = ST_FAULT;
        else if (stop_in)  state_d = ST_IDLE;
        else if (!hall_edge && (settle_cnt_q >= SETTLE_LAST)) state_d = ST_FORECAST;
      end
      ST_FORECAST: begin
        if (fault_hit)     state_d = ST_FAULT;
        else if (stop_in)  state_d = ST_IDLE;
        else if (fc_cnt_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fault_hit)     state_d = ST_FAULT;
        else if (stop_in)  state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clear_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    forecast_enable_out   = (state_q == ST_FORECAST);
    tracking_active_out   = (state_q == ST_RUN);
    fault_out             = (state_q == ST_FAULT);
    state_out             = state_q;
    fault_code_out        = fault_code_q;
    hall_period_out       = period_q;
    hall_period_valid_out = period_valid_q;
  end

  // Counters, fault latch and period measurement
  always_comb begin
    // An edge that keeps us in RUN is by construction a legal step.
    run_edge = (state_q == ST_RUN) && (state_d == ST_RUN) && hall_edge;

    settle_cnt_d = ((state_q == ST_SETTLE) && !hall_edge) ? settle_cnt_q + ONE : '0;
    fc_cnt_d     = (state_q == ST_FORECAST) ? ~fc_cnt_q : 1'b0;

    if ((state_q != ST_RUN) || !stall_check_enable_in || hall_edge) stall_cnt_d = '0;
    else if (stall_cnt_q != CNT_MAX)                                 stall_cnt_d = stall_cnt_q + ONE;
    else                                                             stall_cnt_d = stall_cnt_q;

    fault_code_d = fault_code_q;
    if ((state_q != ST_FAULT) && fault_hit)          fault_code_d = fault_kind;
    else if ((state_q == ST_FAULT) && fault_clear_in) fault_code_d = FC_NONE;

    if (state_q != ST_RUN)           period_cnt_d = '0;
    else if (run_edge)               period_cnt_d = ONE;
    else if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + ONE;
    else                             period_cnt_d = period_cnt_q;

    // The first edge after entering RUN only restarts the period counter.
    period_d       = period_q;
    period_valid_d = 1'b0;
    seen_edge_d    = (state_q == ST_RUN) ? seen_edge_q : 1'b0;
    if (run_edge) begin
      seen_edge_d = 1'b1;
      if (seen_edge_q) begin
        period_d       = period_cnt_q;
        period_valid_d = 1'b1;
      end
    end
    if (state_d == ST_IDLE) period_d = '0;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_code_q   <= FC_NONE;
      settle_cnt_q   <= '0;
      stall_cnt_q    <= '0;
      period_cnt_q   <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      seen_edge_q    <= 1'b0;
      fc_cnt_q       <= 1'b0;
    end else begin
      fault_code_q   <= fault_code_d;
      settle_cnt_q   <= settle_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      period_cnt_q   <= period_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      seen_edge_q    <= seen_edge_d;
      fc_cnt_q       <= fc_cnt_d;
    end
  end

endmodule

// File: tb/tb_rotor_phase_startup_controller.sv
// Self-checking bench for rotor_phase_startup_controller with short settle
// and stall windows. Expected hall periods come from the gaps the bench
// itself puts between hall input changes.
module tb_rotor_phase_startup_controller;

  localparam int DEB    = 4;
  localparam int SETTLE = 16;
  localparam int STALL  = 300;
  localparam int CW     = 24;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_in = 1'b0, stop_in = 1'b0, fault_clear_in = 1'b0;
  logic          stall_check_enable_in = 1'b0;
  logic          hall_u_in = 1'b0, hall_v_in = 1'b0, hall_w_in = 1'b0;
  logic [2:0]    hall_filtered_out;
  logic          forecast_enable_out, tracking_active_out;
  logic [CW-1:0] hall_period_out;
  logic          hall_period_valid_out;
  logic [2:0]    state_out;
  logic          fault_out;
  logic [1:0]    fault_code_out;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_q[$];

  // Forward electrical order of legal hall codes.
  logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  rotor_phase_startup_controller #(
    .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE), .STALL_TIMEOUT(STALL), .CNT_WIDTH(CW)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start_in(start_in), .stop_in(stop_in),
    .fault_clear_in(fault_clear_in), .stall_check_enable_in(stall_check_enable_in),
    .hall_u_in(hall_u_in), .hall_v_in(hall_v_in), .hall_w_in(hall_w_in),
    .hall_filtered_out(hall_filtered_out), .forecast_enable_out(forecast_enable_out),
    .tracking_active_out(tracking_active_out), .hall_period_out(hall_period_out),
    .hall_period_valid_out(hall_period_valid_out), .state_out(state_out),
    .fault_out(fault_out), .fault_code_out(fault_code_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Record every period strobe, sampled on the inactive edge.
  always @(negedge sys_clk)
    if (reset_n && hall_period_valid_out) strobe_q.push_back(int'(hall_period_out));

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_hall(input logic [2:0] code);
    {hall_u_in, hall_v_in, hall_w_in} = code;
  endtask

  task automatic clear_fault();
    fault_clear_in = 1'b1; cycles(1); fault_clear_in = 1'b0;
  endtask

  // Return to IDLE, present a steady code and start; wait (bounded) for RUN.
  task automatic go_run(input logic [2:0] code);
    int k;
    stop_in = 1'b1; cycles(1); stop_in = 1'b0;
    set_hall(code); cycles(DEB + 6);
    start_in = 1'b1; cycles(1); start_in = 1'b0;
    k = 0;
    while (state_out !== 3'd3 && k < 60) begin cycles(1); k++; end
    n_cmp++;
    if (state_out !== 3'd3) begin
      n_bad++; $display("FAIL go_run: state %0d want 3", state_out);
    end
  endtask

  task automatic test_reset();
    set_hall(3'b101);
    reset_n = 1'b0; cycles(3);
    n_cmp++;
    if ({hall_filtered_out, forecast_enable_out, tracking_active_out, hall_period_out,
         hall_period_valid_out, state_out, fault_out, fault_code_out} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: state %0d filt %b want all zero", state_out, hall_filtered_out);
    end
    reset_n = 1'b1;
    cycles(2 + DEB - 1);
    n_cmp++;
    if (hall_filtered_out !== 3'b000) begin
      n_bad++; $display("FAIL latency_early: filt %b want 000", hall_filtered_out);
    end
    cycles(1);
    n_cmp++;
    if (hall_filtered_out !== 3'b101) begin
      n_bad++; $display("FAIL latency_exact: filt %b want 101", hall_filtered_out);
    end
    $display("test_reset: done");
  endtask

  task automatic test_startup();
    int fc_first = -1, fc_count = 0;
    start_in = 1'b1; cycles(1); start_in = 1'b0;
    n_cmp++;
    if (state_out !== 3'd1) begin
      n_bad++; $display("FAIL startup_settle: state %0d want 1", state_out);
    end
    for (int k = 2; k <= SETTLE + 3; k++) begin
      cycles(1);
      if (forecast_enable_out) begin fc_count++; if (fc_first < 0) fc_first = k; end
    end
    n_cmp++;
    if (fc_count != 2) begin n_bad++; $display("FAIL forecast_len: %0d cycles want 2", fc_count); end
    n_cmp++;
    if (fc_first != SETTLE + 1) begin
      n_bad++; $display("FAIL forecast_start: cycle %0d want %0d", fc_first, SETTLE + 1);
    end
    n_cmp++;
    if (state_out !== 3'd3 || tracking_active_out !== 1'b1 || forecast_enable_out !== 1'b0) begin
      n_bad++; $display("FAIL startup_run: state %0d trk %b fc %b want 3 1 0",
                        state_out, tracking_active_out, forecast_enable_out);
    end
    $display("test_startup: forecast cycles %0d first %0d", fc_count, fc_first);
  endtask

  task automatic test_forward_period();
    strobe_q.delete();
    set_hall(3'b100); cycles(500);
    n_cmp++;
    if (strobe_q.size() != 0) begin n_bad++; $display("FAIL first_edge_strobe: %0d strobes want 0", strobe_q.size()); end
    set_hall(3'b110); cycles(500);
    set_hall(3'b010); cycles(500);
    n_cmp++;
    if (strobe_q.size() != 2) begin
      n_bad++; $display("FAIL fwd_strobes: %0d strobes want 2", strobe_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (strobe_q[i] != 500) begin n_bad++; $display("FAIL fwd_period%0d: %0d want 500", i, strobe_q[i]); end
      end
    end
    n_cmp++;
    if (state_out !== 3'd3 || fault_out !== 1'b0) begin
      n_bad++; $display("FAIL fwd_nofault: state %0d fault %b want 3 0", state_out, fault_out);
    end
    $display("test_forward_period: %0d strobes", strobe_q.size());
  endtask

  task automatic test_skip_fault();
    go_run(3'b101);
    set_hall(3'b110); cycles(DEB + 4);
    n_cmp++;
    if (state_out !== 3'd4 || fault_out !== 1'b1 || fault_code_out !== 2'b10 || tracking_active_out !== 1'b0) begin
      n_bad++; $display("FAIL skip_fault: state %0d fault %b code %b trk %b want 4 1 10 0",
                        state_out, fault_out, fault_code_out, tracking_active_out);
    end
    start_in = 1'b1; stop_in = 1'b1; cycles(2); start_in = 1'b0; stop_in = 1'b0;
    n_cmp++;
    if (state_out !== 3'd4) begin n_bad++; $display("FAIL fault_ignores_stop: state %0d want 4", state_out); end
    clear_fault();
    n_cmp++;
    if (state_out !== 3'd0 || fault_out !== 1'b0 || fault_code_out !== 2'b00) begin
      n_bad++; $display("FAIL fault_clear: state %0d fault %b code %b want 0 0 00",
                        state_out, fault_out, fault_code_out);
    end
    $display("test_skip_fault: done");
  endtask

  task automatic test_fault_beats_stop();
    go_run(3'b101);
    set_hall(3'b011); cycles(2 + DEB);
    stop_in = 1'b1; cycles(1); stop_in = 1'b0;
    n_cmp++;
    if (state_out !== 3'd4 || fault_code_out !== 2'b10) begin
      n_bad++; $display("FAIL fault_vs_stop: state %0d code %b want 4 10", state_out, fault_code_out);
    end
    clear_fault();
    $display("test_fault_beats_stop: done");
  endtask

  task automatic test_illegal_settle();
    stop_in = 1'b1; cycles(1); stop_in = 1'b0;
    set_hall(3'b101); cycles(DEB + 6);
    start_in = 1'b1; cycles(1); start_in = 1'b0;
    set_hall(3'b111); cycles(DEB + 6);
    n_cmp++;
    if (state_out !== 3'd4 || fault_code_out !== 2'b01) begin
      n_bad++; $display("FAIL illegal_settle: state %0d code %b want 4 01", state_out, fault_code_out);
    end
    clear_fault();
    $display("test_illegal_settle: done");
  endtask

  task automatic test_glitch();
    int bad_cycles = 0;
    go_run(3'b101);
    strobe_q.delete();
    set_hall(3'b001); cycles(2); set_hall(3'b101);
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      if (hall_filtered_out !== 3'b101) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL glitch_filtered: %0d changed cycles want 0", bad_cycles); end
    n_cmp++;
    if (state_out !== 3'd3 || strobe_q.size() != 0) begin
      n_bad++; $display("FAIL glitch_state: state %0d strobes %0d want 3 0", state_out, strobe_q.size());
    end
    $display("test_glitch: done");
  endtask

  task automatic test_stall();
    stall_check_enable_in = 1'b1;
    go_run(3'b101);
    cycles(STALL - 3);
    n_cmp++;
    if (state_out !== 3'd3) begin n_bad++; $display("FAIL stall_early: state %0d want 3", state_out); end
    cycles(4);
    n_cmp++;
    if (state_out !== 3'd4 || fault_code_out !== 2'b11) begin
      n_bad++; $display("FAIL stall_fault: state %0d code %b want 4 11", state_out, fault_code_out);
    end
    clear_fault();
    stall_check_enable_in = 1'b0;
    go_run(3'b101);
    cycles(STALL + 50);
    n_cmp++;
    if (state_out !== 3'd3 || fault_out !== 1'b0) begin
      n_bad++; $display("FAIL stall_disabled: state %0d fault %b want 3 0", state_out, fault_out);
    end
    $display("test_stall: done");
  endtask

  // Random legal walk; each period must equal the gap before that edge.
  task automatic test_random_walk();
    int idx = 0;
    int gaps[$];
    stall_check_enable_in = 1'($urandom_range(0, 1));
    go_run(seq[0]);
    strobe_q.delete();
    for (int e = 0; e < 8; e++) begin
      int d;
      d = $urandom_range(20, 250);
      idx = ($urandom_range(0, 1) == 1) ? (idx + 1) % 6 : (idx + 5) % 6;
      set_hall(seq[idx]);
      if (e < 7) gaps.push_back(d);
      $display("random edge %0d: code %b gap %0d", e, seq[idx], d);
      cycles(d);
    end
    n_cmp++;
    if (strobe_q.size() != 7) begin
      n_bad++; $display("FAIL rand_strobes: %0d want 7", strobe_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (strobe_q[i] != gaps[i]) begin
          n_bad++; $display("FAIL rand_period%0d: %0d want %0d", i, strobe_q[i], gaps[i]);
        end
      end
    end
    n_cmp++;
    if (state_out !== 3'd3) begin n_bad++; $display("FAIL rand_state: state %0d want 3", state_out); end
    stall_check_enable_in = 1'b0;
  endtask

  task automatic test_stop_start();
    start_in = 1'b1; stop_in = 1'b1; cycles(1); start_in = 1'b0; stop_in = 1'b0;
    n_cmp++;
    if (state_out !== 3'd0 || tracking_active_out !== 1'b0 || hall_period_out !== '0) begin
      n_bad++; $display("FAIL stop_start: state %0d trk %b period %0d want 0 0 0",
                        state_out, tracking_active_out, hall_period_out);
    end
    $display("test_stop_start: done");
  endtask

  task automatic test_reset_mid_forecast();
    int k = 0;
    stop_in = 1'b1; cycles(1); stop_in = 1'b0;
    set_hall(3'b101); cycles(DEB + 6);
    start_in = 1'b1; cycles(1); start_in = 1'b0;
    while (state_out !== 3'd2 && k < 40) begin cycles(1); k++; end
    n_cmp++;
    if (state_out !== 3'd2) begin n_bad++; $display("FAIL reach_forecast: state %0d want 2", state_out); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({hall_filtered_out, forecast_enable_out, tracking_active_out, hall_period_out,
         hall_period_valid_out, state_out, fault_out, fault_code_out} !== '0) begin
      n_bad++; $display("FAIL async_reset: state %0d fc %b filt %b want all zero",
                        state_out, forecast_enable_out, hall_filtered_out);
    end
    cycles(2); reset_n = 1'b1; cycles(2);
    $display("test_reset_mid_forecast: done");
  endtask

  initial begin
    test_reset();
    test_startup();
    test_forward_period();
    test_skip_fault();
    test_fault_beats_stop();
    test_illegal_settle();
    test_glitch();
    test_stall();
    test_random_walk();
    test_stop_start();
    test_reset_mid_forecast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotor_phase_startup_controller.md
Name: rotor_phase_startup_controller

Overview:
- Sequences rotor-angle acquisition for the PMSM FOC loop.
- Filters and validates the hall inputs, then pulses the phase-forecast enable of the electrical-angle calculator once the hall code is stable.
- Releases that calculator into tracking mode and supervises it: illegal hall codes, skipped hall steps and stall.
- Measures the hall-edge period for the speed loop.
- Sits between the top-level motor-control FSM and the electrical-angle calculator.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive equal synced samples before a hall code is accepted as filtered.
- SETTLE_CYCLES, 1000: cycles the filtered code must stay unchanged in SETTLE before forecast.
- STALL_TIMEOUT, 2000000: cycles without a filtered hall edge in RUN that declare a stall.
- CNT_WIDTH, 24: width of the period and timeout counters.

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start_in  in  1  request startup (level or pulse)
- stop_in  in  1  abort/stop, returns to IDLE
- fault_clear_in  in  1  clear latched fault
- stall_check_enable_in  in  1  nonzero speed commanded; enables the stall check
- hall_u_in, hall_v_in, hall_w_in  in  1 each  raw hall sensors (asynchronous)
- hall_filtered_out  out  3  {u,v,w} after synchronisation and debounce
- forecast_enable_out  out  1  drives the calculator's phase-forecast enable
- tracking_active_out  out  1  high in RUN; angle is valid for the FOC
- hall_period_out  out  CNT_WIDTH  cycles between the last two filtered hall edges
- hall_period_valid_out  out  1  one-cycle strobe on each period update
- state_out  out  3  IDLE=0, SETTLE=1, FORECAST=2, RUN=3, FAULT=4
- fault_out  out  1  latched fault
- fault_code_out  out  2  01 illegal code, 10 skipped step, 11 stall

Behaviour:
Reset values:
- All outputs 0.
- state_out = IDLE.
- hall_filtered_out = 0.

Hall input path:
- 2-flop synchroniser.
- Debounce counter: the synced value is copied to hall_filtered_out after DEBOUNCE_CYCLES consecutive equal samples. Latency from input change to output is 2+DEBOUNCE_CYCLES cycles.
- A filtered edge is any cycle in which hall_filtered_out changes.

Hall codes:
- Legal codes: 101, 100, 110, 010, 011, 001.
- Forward cycle order: 101→100→110→010→011→001→101.
- 000 and 111 are illegal.
- A legal edge is a change to the successor or predecessor in the forward cycle. Any other change is a skipped step.

FSM:
- IDLE: start_in=1 → SETTLE, settle counter cleared.
- SETTLE:
  - Counter increments each cycle and clears on any filtered edge.
  - Filtered code illegal → FAULT, code 01.
  - Counter reaches SETTLE_CYCLES-1 with a legal code → FORECAST.
- FORECAST:
  - Exactly 2 cycles, forecast_enable_out=1 for both; this covers the calculator's internal hall register.
  - Illegal code → FAULT, code 01.
  - Otherwise → RUN.
- RUN:
  - tracking_active_out=1.
  - Filtered illegal code → FAULT, code 01.
  - Skipped step → FAULT, code 10.
  - stall_check_enable_in=1 and the timeout counter reaches STALL_TIMEOUT → FAULT, code 11.
  - The timeout counter clears on each filtered edge and while stall_check_enable_in=0.
- FAULT:
  - fault_out=1; fault_code_out holds the first fault code.
  - forecast_enable_out=0 and tracking_active_out=0.
  - fault_clear_in=1 → IDLE and clears fault_out and fault_code_out.
  - stop_in and start_in are ignored.

Priorities:
- stop_in=1 in any non-FAULT state → IDLE next cycle.
- stop_in beats start_in in the same cycle.
- A fault detected in the same cycle as stop_in wins: the next state is FAULT.
- When an illegal code and a stall coincide, code 01 is reported.

Period measurement:
- Runs in RUN only. The counter saturates at 2^CNT_WIDTH-1.
- On each legal filtered edge: hall_period_out ← counter value, counter ← 1.
- hall_period_valid_out pulses only from the second edge after entering RUN; the first edge only restarts the counter.
- hall_period_out holds its value otherwise and clears on entry to IDLE.

Decomposition:
- Shared package/include (project_param): hall-code constants, the forward successor table, and the state encoding.
- One natural sub-module: hall_input_filter (synchroniser + debounce, parameter DEBOUNCE_CYCLES) producing hall_filtered_out and an edge strobe.
- FSM, supervision and period counter live in the top.

Test Plan:
- Reset, start_in pulse, hall=101 steady (SETTLE_CYCLES=16):
  - state 1 after 1 cycle.
  - forecast_enable_out high for exactly 2 cycles after 16 settle cycles.
  - Then state 3 with tracking_active_out=1.
- RUN, forward sequence 101→100→110→010 with 500-cycle spacing:
  - No strobe on the first edge.
  - hall_period_out=500 with one-cycle strobes on the 2nd and 3rd edges.
  - No fault.
- RUN, step 101→110 (skip):
  - FAULT, fault_code_out=10, tracking_active_out=0.
  - fault_clear_in → IDLE with fault cleared.
- SETTLE with hall=111 held past debounce → FAULT, code 01.
- A 2-cycle glitch on hall_u (DEBOUNCE_CYCLES=4) → hall_filtered_out unchanged, no edge, no fault.
- RUN, stall_check_enable_in=1, no edges for STALL_TIMEOUT cycles → FAULT, code 11. Repeating with stall_check_enable_in=0 → no fault.
- stop_in and start_in asserted together in RUN → IDLE; asserting reset_n low mid-FORECAST → all outputs 0 immediately.
